// File: rtl/mtimer_if.sv
// Request/response bus between system_bus and the machine timer.
// Same single-cycle handshake as the RAM device port.
interface mtimer_if;
  logic [31:0] rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;

  modport master (
    output rw_address, read_request, write_data, write_strobe, write_request,
    input  read_data, read_response, write_response
  );

  modport slave (
    input  rw_address, read_request, write_data, write_strobe, write_request,
    output read_data, read_response, write_response
  );
endinterface

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit prescaled mtime, 64-bit mtimecmp and a
// registered level interrupt, behind a one-cycle request/response bus.
module mtimer #(
  parameter int unsigned CLOCK_DIV = 1
) (
  input  logic     clock,
  input  logic     reset,
  mtimer_if.slave  bus,
  output logic     irq
);

  typedef enum logic [4:0] {
    OFF_CTRL   = 5'h00,
    OFF_MTIMEL = 5'h04,
    OFF_MTIMEH = 5'h08,
    OFF_CMPL   = 5'h0C,
    OFF_CMPH   = 5'h10
  } offset_e;

  localparam logic [15:0] PRESCALE_LAST = 16'(CLOCK_DIV - 1);

  logic        enable;
  logic [15:0] prescaler;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] snapshot;

  logic [4:0]  offset;
  logic        wr_ctrl, wr_mtimel, wr_mtimeh, wr_cmpl, wr_cmph;
  logic        rd_mtimel;
  logic        tick;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_next;
  logic [15:0] prescaler_next;
  logic        enable_next;
  logic [31:0] read_value;

  // Upper address bits are decoded by system_bus before the request lands here.
  logic unused_address;
  assign unused_address = &{1'b0, bus.rw_address[31:5]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  strobe);
    logic [31:0] result;
    result = old_value;
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) result[8*b +: 8] = new_value[8*b +: 8];
    end
    return result;
  endfunction

  assign offset    = bus.rw_address[4:0];
  assign wr_ctrl   = bus.write_request && (offset == OFF_CTRL);
  assign wr_mtimel = bus.write_request && (offset == OFF_MTIMEL);
  assign wr_mtimeh = bus.write_request && (offset == OFF_MTIMEH);
  assign wr_cmpl   = bus.write_request && (offset == OFF_CMPL);
  assign wr_cmph   = bus.write_request && (offset == OFF_CMPH);
  assign rd_mtimel = bus.read_request  && (offset == OFF_MTIMEL);

  assign tick      = enable && (prescaler == PRESCALE_LAST);
  assign mtime_inc = mtime + 64'(tick);

  // Written bytes win over a simultaneous tick; unwritten bytes keep the increment.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    mtime_next = mtime_inc;
    if (wr_mtimel)
      mtime_next[31:0] = merge_bytes(mtime_inc[31:0], bus.write_data, bus.write_strobe);
    if (wr_mtimeh)
      mtime_next[63:32] = merge_bytes(mtime_inc[63:32], bus.write_data, bus.write_strobe);
  end

  always_comb begin
    mtimecmp_next = mtimecmp;
    if (wr_cmpl)
      mtimecmp_next[31:0] = merge_bytes(mtimecmp[31:0], bus.write_data, bus.write_strobe);
    if (wr_cmph)
      mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], bus.write_data, bus.write_strobe);
  end

  always_comb begin
    enable_next = enable;
    if (wr_ctrl && bus.write_strobe[0]) enable_next = bus.write_data[0];
  end

  // A CTRL access restarts the tick period even when no byte is enabled.
  always_comb begin
    prescaler_next = prescaler;
    if (wr_ctrl)
      prescaler_next = '0;
    else if (enable)
      prescaler_next = tick ? 16'd0 : prescaler + 16'd1;
  end

  always_comb begin
    read_value = '0;
    case (offset)
      OFF_CTRL:   read_value = {31'd0, enable};
      OFF_MTIMEL: read_value = mtime[31:0];
      OFF_MTIMEH: read_value = snapshot;
      OFF_CMPL:   read_value = mtimecmp[31:0];
      OFF_CMPH:   read_value = mtimecmp[63:32];
      default:    read_value = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      enable             <= 1'b0;
      prescaler          <= '0;
      mtime              <= '0;
      mtimecmp           <= '1;
      snapshot           <= '0;
      bus.read_data      <= '0;
      bus.read_response  <= 1'b0;
      bus.write_response <= 1'b0;
      irq                <= 1'b0;
    end else begin
      enable             <= enable_next;
      prescaler          <= prescaler_next;
      mtime              <= mtime_next;
      mtimecmp           <= mtimecmp_next;
      bus.read_response  <= bus.read_request;
      bus.write_response <= bus.write_request;
      if (bus.read_request) bus.read_data <= read_value;
      if (rd_mtimel)        snapshot      <= mtime[63:32];
      irq                <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Directed-vector bench for mtimer: one instance at CLOCK_DIV=1 and one at
// CLOCK_DIV=4 share clock and reset; inputs change on the falling edge.
module tb_mtimer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic irq1, irq4;
  int   vectors = 0;
  int   misses  = 0;

  mtimer_if bus1 ();
  mtimer_if bus4 ();

  mtimer #(.CLOCK_DIV(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave), .irq(irq1));
  mtimer #(.CLOCK_DIV(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave), .irq(irq4));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit d4, input logic rd, input logic wr, input logic [4:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    if (d4) begin
      bus4.read_request  = rd;
      bus4.write_request = wr;
      bus4.rw_address    = {27'd0, addr};
      bus4.write_data    = data;
      bus4.write_strobe  = strb;
    end else begin
      bus1.read_request  = rd;
      bus1.write_request = wr;
      bus1.rw_address    = {27'd0, addr};
      bus1.write_data    = data;
      bus1.write_strobe  = strb;
    end
  endtask

  task automatic idle(input bit d4);
    drive(d4, 1'b0, 1'b0, 5'h00, 32'h0, 4'h0);
  endtask

  // Called on a falling edge; returns on the falling edge after the response.
  task automatic bus_write(input bit d4, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    drive(d4, 1'b0, 1'b1, addr, data, strb);
    @(negedge clock);
    idle(d4);
    check($sformatf("wresp@%h", addr), d4 ? bus4.write_response : bus1.write_response, 1);
  endtask

  task automatic bus_read(input bit d4, input string tag, input logic [4:0] addr,
                          input logic [31:0] exp);
    drive(d4, 1'b1, 1'b0, addr, 32'h0, 4'h0);
    @(negedge clock);
    idle(d4);
    check({tag, "_resp"}, d4 ? bus4.read_response : bus1.read_response, 1);
    check(tag, d4 ? bus4.read_data : bus1.read_data, exp);
  endtask

  initial begin
    idle(1'b0);
    idle(1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset state
    check("idle_rresp", bus1.read_response, 0);
    check("idle_wresp", bus1.write_response, 0);
    check("reset_irq", irq1, 0);
    bus_read(1'b0, "reset_cmpl", 5'h0C, 32'hFFFF_FFFF);
    bus_read(1'b0, "reset_cmph", 5'h10, 32'hFFFF_FFFF);
    bus_read(1'b0, "reset_mtimel", 5'h04, 32'h0);
    bus_read(1'b0, "reset_ctrl", 5'h00, 32'h0);

    // Tick rate at CLOCK_DIV=4: one increment every 4 enabled cycles
    bus_write(1'b1, 5'h00, 32'h1, 4'hF);
    repeat (40) @(negedge clock);
    bus_read(1'b1, "div4_mtimel", 5'h04, 32'd10);
    bus_write(1'b1, 5'h00, 32'h0, 4'hF);
    bus_read(1'b1, "div4_frozen_a", 5'h04, 32'd10);
    repeat (100) @(negedge clock);
    bus_read(1'b1, "div4_frozen_b", 5'h04, 32'd10);

    // Low-to-high carry and snapshot
    bus_write(1'b0, 5'h08, 32'h0, 4'hF);
    bus_write(1'b0, 5'h04, 32'hFFFF_FFFE, 4'hF);
    bus_write(1'b0, 5'h00, 32'h1, 4'hF);
    repeat (3) @(negedge clock);
    bus_read(1'b0, "carry_mtimel", 5'h04, 32'h0000_0001);
    bus_read(1'b0, "carry_snap", 5'h08, 32'h0000_0001);

    // Full 64-bit wrap, then a byte write colliding with a tick
    bus_write(1'b0, 5'h00, 32'h0, 4'hF);
    bus_write(1'b0, 5'h08, 32'hFFFF_FFFF, 4'hF);
    bus_write(1'b0, 5'h04, 32'hFFFF_FFFF, 4'hF);
    bus_write(1'b0, 5'h00, 32'h1, 4'hF);
    @(negedge clock);
    bus_read(1'b0, "wrap_mtimel", 5'h04, 32'h0);
    bus_read(1'b0, "wrap_snap", 5'h08, 32'h0);
    bus_write(1'b0, 5'h04, 32'h0000_AB00, 4'b0010);
    bus_read(1'b0, "collide_mtimel", 5'h04, 32'h0000_AB03);

    // Interrupt assert and clear
    bus_write(1'b0, 5'h00, 32'h0, 4'hF);
    bus_write(1'b0, 5'h08, 32'h0, 4'hF);
    bus_write(1'b0, 5'h04, 32'h0, 4'hF);
    bus_write(1'b0, 5'h10, 32'h0, 4'hF);
    bus_write(1'b0, 5'h0C, 32'h20, 4'hF);
    check("irq_before", irq1, 0);
    bus_write(1'b0, 5'h00, 32'h1, 4'hF);
    repeat (32) @(negedge clock);
    check("irq_at_match", irq1, 0);
    @(negedge clock);
    check("irq_rise", irq1, 1);
    bus_write(1'b0, 5'h0C, 32'h1000, 4'hF);
    check("irq_lag", irq1, 1);
    @(negedge clock);
    check("irq_clear", irq1, 0);
    bus_write(1'b0, 5'h00, 32'h0, 4'hF);

    // Byte strobes
    bus_write(1'b0, 5'h0C, 32'hFFFF_FFFF, 4'hF);
    bus_write(1'b0, 5'h0C, 32'hAABB_CCDD, 4'b0101);
    bus_read(1'b0, "strobe_0101", 5'h0C, 32'hFFBB_FFDD);
    bus_write(1'b0, 5'h0C, 32'h1234_5678, 4'b0000);
    bus_read(1'b0, "strobe_none", 5'h0C, 32'hFFBB_FFDD);

    // Read and write in the same cycle: read sees the pre-write value
    drive(1'b0, 1'b1, 1'b1, 5'h0C, 32'h1111_1111, 4'hF);
    @(negedge clock);
    idle(1'b0);
    check("rw_rresp", bus1.read_response, 1);
    check("rw_wresp", bus1.write_response, 1);
    check("rw_old", bus1.read_data, 32'hFFBB_FFDD);
    bus_read(1'b0, "rw_new", 5'h0C, 32'h1111_1111);

    // Unmapped and misaligned offsets
    bus_read(1'b0, "unmapped_14", 5'h14, 32'h0);
    bus_read(1'b0, "misalign_05", 5'h05, 32'h0);
    bus_write(1'b0, 5'h14, 32'hDEAD_BEEF, 4'hF);
    bus_read(1'b0, "cmpl_kept", 5'h0C, 32'h1111_1111);

    // Reset mid-count with a concurrent request
    bus_write(1'b0, 5'h10, 32'h0, 4'hF);
    bus_write(1'b0, 5'h0C, 32'h0, 4'hF);
    bus_write(1'b0, 5'h00, 32'h1, 4'hF);
    repeat (5) @(negedge clock);
    check("pre_reset_irq", irq1, 1);
    drive(1'b0, 1'b1, 1'b0, 5'h04, 32'h0, 4'h0);
    @(negedge clock);
    check("pre_reset_data_nonzero", (bus1.read_data != 32'h0), 1);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 5'h04, 32'h55, 4'hF);
    @(negedge clock);
    idle(1'b0);
    reset = 1'b1;
    check("rst_rresp", bus1.read_response, 0);
    check("rst_wresp", bus1.write_response, 0);
    check("rst_rdata", bus1.read_data, 32'h0);
    check("rst_irq", irq1, 0);
    bus_read(1'b0, "rst_cmpl", 5'h0C, 32'hFFFF_FFFF);
    bus_read(1'b0, "rst_cmph", 5'h10, 32'hFFFF_FFFF);
    bus_read(1'b0, "rst_ctrl", 5'h00, 32'h0);
    repeat (4) @(negedge clock);
    bus_read(1'b0, "rst_mtimel", 5'h04, 32'h0);
    bus_read(1'b0, "rst_snap", 5'h08, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped RISC-V machine timer: 64-bit free-running `mtime` counter, 64-bit `mtimecmp` compare register, level timer interrupt.
- Attaches as a device port of `system_bus`, beside `ram_memory` and `uart`.
- Drives the core's `irq_timer` input, which is currently tied to zero in the SoC top.
- Uses the same request/response bus handshake as the RAM device.

Parameters:
- CLOCK_DIV, 1, clock cycles per `mtime` tick; legal range 1..65535; 1 = tick every enabled cycle.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- rw_address  input  32  byte address; only bits [4:0] decoded (bus has already selected this device)
- read_data  output  32  read data, valid while read_response=1
- read_request  input  1  read strobe, one cycle per access
- read_response  output  1  read completion
- write_data  input  32  write data
- write_strobe  input  4  byte enables; bit n enables write_data[8n+7:8n]
- write_request  input  1  write strobe, one cycle per access
- write_response  output  1  write completion
- irq  output  1  timer interrupt, level, registered

Behaviour:
- Register map (offset = rw_address[4:0]):
  - 0x00 CTRL: bit0 = enable; other bits read 0.
  - 0x04 MTIMEL: mtime[31:0].
  - 0x08 MTIMEH: read returns snapshot; write updates mtime[63:32].
  - 0x0C MTIMECMPL: mtimecmp[31:0].
  - 0x10 MTIMECMPH: mtimecmp[63:32].
  - Any other offset (including offsets with bits [1:0] != 0): read returns 0, write ignored, response still given.
- Reset (reset=0 at a clock edge):
  - enable=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, snapshot=0.
  - read_data=0, read_response=0, write_response=0, irq=0.
  - Reset overrides any request in the same cycle; that request gets no response.
- Handshake:
  - read_response and write_response assert exactly one cycle after the corresponding request, for one cycle.
  - read_data is registered and holds its value until the next read.
  - Back-to-back requests on consecutive cycles are each answered on their following cycle (throughput 1 per cycle).
  - If read_request and write_request are both high in one cycle, the read returns the pre-write value and the write is applied; both responses assert next cycle.
- Byte strobes:
  - Writes update only the bytes enabled by write_strobe.
  - write_strobe=0 updates nothing but still produces a response.
- Snapshot:
  - A read of MTIMEL returns mtime[31:0] and, in the same cycle, captures mtime[63:32] into the snapshot.
  - A read of MTIMEH returns the snapshot. Software reads L then H to get a tear-free 64-bit value.
- Prescaler:
  - While enable=1, the prescaler counts 0..CLOCK_DIV-1. On its terminal count it wraps to 0 and mtime increments by 1.
  - While enable=0, prescaler and mtime hold.
  - Any write to CTRL clears the prescaler to 0.
- Counter arithmetic:
  - mtime is a 64-bit unsigned counter; FFFF_FFFF_FFFF_FFFF + 1 wraps to 0.
  - The carry from the low word into the high word occurs in the same cycle.
- Write vs tick collision: a write to MTIMEL or MTIMEH in a tick cycle wins for the bytes written. Unwritten bytes take the incremented value.
- Interrupt:
  - Every cycle, irq <= (mtime >= mtimecmp), 64-bit unsigned compare, using the register values before this edge.
  - irq therefore lags a register change by one cycle.
  - irq is independent of enable; it is cleared only by software raising mtimecmp or lowering mtime.
  - Because of the one-cycle lag, a mtimecmp update takes effect on irq two cycles after the write_request.

Test Plan:
- Reset check: after reset, read 0x0C and 0x10 -> 0xFFFFFFFF both, response 1 cycle after request, irq=0; read 0x04 -> 0.
- Tick rate: CLOCK_DIV=4, write CTRL=1, wait 40 cycles, read MTIMEL -> 10 (±1 for access timing); with enable=0 the value stays constant over 100 cycles.
- Carry and snapshot: write MTIMEH=0, MTIMEL=0xFFFFFFFE, enable, CLOCK_DIV=1; after 3 cycles read MTIMEL -> 0x00000001 (±1), then read MTIMEH -> 0x00000001 (the snapshot taken with the low-word read).
- Interrupt assert/clear: mtimecmp=0x0000_0000_0000_0020, enable; irq rises the cycle after mtime reaches 0x20. Write MTIMECMPL=0x1000 -> irq=0 two cycles after the write_request.
- Strobes: write 0xAABBCCDD to 0x0C with strobe 4'b0101 over 0xFFFFFFFF -> read 0xFFBBFFDD; strobe 0 -> response given, value unchanged.
- Edge cases: read of offset 0x14 -> 0 with response. Reset asserted mid-count with a concurrent request -> all registers at reset values and no response next cycle.
